alu_op_sequencer: RTL and testbench

// Sequences the shared combinational ALU from one data bus and one load strobe (switches + debounced button).

---
 rtl/alu_op_sequencer_pkg.sv | 32 +++
 rtl/alu_op_sequencer_if.sv | 23 ++
 rtl/alu_op_sequencer_alu.sv | 32 +++
 rtl/alu_op_sequencer.sv | 112 +++++++++++
 tb/tb_alu_op_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU operation sequencer: opcode encodings,
// FSM state encodings and the supported-opcode check.
package alu_op_sequencer_pkg;

    localparam int COD_OP_W = 6;

    localparam logic [COD_OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [COD_OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [COD_OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [COD_OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [COD_OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [COD_OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [COD_OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [COD_OP_W-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;

    function automatic logic is_supported_op(input logic [COD_OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Board-side bus of the sequencer: shared data bus, load/clear strobes,
// result and status outputs.
interface alu_op_sequencer_if #(
    parameter int NBITS = 8
) ();
    logic [NBITS-1:0] i_data;
    logic             i_load;
    logic             i_clear;
    logic [NBITS-1:0] o_result;
    logic             o_valid;
    logic             o_error;
    logic [2:0]       o_state;

    modport slave (
        input  i_data, i_load, i_clear,
        output o_result, o_valid, o_error, o_state
    );

    modport master (
        output i_data, i_load, i_clear,
        input  o_result, o_valid, o_error, o_state
    );
endinterface

// File: rtl/alu_op_sequencer_alu.sv
// Combinational ALU: signed two's complement, wrap-around, no flags.
// Unsupported opcodes yield zero.
module alu_op_sequencer_alu
    import alu_op_sequencer_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int COD_OP = COD_OP_W
) (
    input  logic [NBITS-1:0]  a_i,
    input  logic [NBITS-1:0]  b_i,
    input  logic [COD_OP-1:0] op_i,
    output logic [NBITS-1:0]  result_o
);

    // Opcode decode; shift amount is B taken as unsigned, so large B
    // naturally saturates to zero (SRL) or sign fill (SRA).
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_SRA:  result_o = $signed(a_i) >>> b_i;
            OP_SRL:  result_o = a_i >> b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer: three load edges capture A, B and the opcode, one execute
// cycle registers the ALU result, which is then held with o_valid until
// the next load edge starts a new operation.
//
// state      | meaning
// WAIT_A     | waiting for load edge carrying operand A
// WAIT_B     | waiting for load edge carrying operand B
// WAIT_OP    | waiting for load edge carrying the opcode
// EXEC       | single cycle, registers ALU output (load edges ignored)
// DONE       | result held; a load edge captures a new A
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int COD_OP = COD_OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_sequencer_if.slave bus
);

    seq_state_t        state_q;
    logic [NBITS-1:0]  op_a_q;
    logic [NBITS-1:0]  op_b_q;
    logic [COD_OP-1:0] op_code_q;
    logic [NBITS-1:0]  result_q;
    logic              valid_q;
    logic              error_q;
    logic              load_prev_q;
    logic              load_edge_d;
    logic [NBITS-1:0]  alu_out;

    // Rising-edge detect on the debounced load level.
    assign load_edge_d = bus.i_load & ~load_prev_q;

    alu_op_sequencer_alu #(
        .NBITS  (NBITS),
        .COD_OP (COD_OP)
    ) u_alu (
        .a_i      (op_a_q),
        .b_i      (op_b_q),
        .op_i     (op_code_q),
        .result_o (alu_out)
    );

    // Sequencing FSM with registered operands and outputs. load_prev resets
    // high so a load already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_code_q   <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            load_prev_q <= 1'b1;
        end else begin
            load_prev_q <= bus.i_load;
            if (bus.i_clear) begin
                state_q   <= ST_WAIT_A;
                op_a_q    <= '0;
                op_b_q    <= '0;
                op_code_q <= '0;
                result_q  <= '0;
                valid_q   <= 1'b0;
                error_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_WAIT_A, ST_DONE: begin
                        if (load_edge_d) begin
                            op_a_q  <= bus.i_data;
                            valid_q <= 1'b0;
                            error_q <= 1'b0;
                            state_q <= ST_WAIT_B;
                        end
                    end
                    ST_WAIT_B: begin
                        if (load_edge_d) begin
                            op_b_q  <= bus.i_data;
                            state_q <= ST_WAIT_OP;
                        end
                    end
                    ST_WAIT_OP: begin
                        if (load_edge_d) begin
                            op_code_q <= bus.i_data[COD_OP-1:0];
                            state_q   <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        if (is_supported_op(op_code_q)) begin
                            result_q <= alu_out;
                            error_q  <= 1'b0;
                        end else begin
                            result_q <= '0;
                            error_q  <= 1'b1;
                        end
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                    default: state_q <= ST_WAIT_A;
                endcase
            end
        end
    end

    assign bus.o_result = result_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_error  = error_q;
    assign bus.o_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_op_sequencer_if #(.NBITS(8)) bus ();

    alu_op_sequencer #(.NBITS(8), .COD_OP(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU from the arithmetic definitions, using integers.
    function automatic int ref_supported(input logic [5:0] op);
        logic [5:0] ops [8];
        ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b100110, 6'b100111, 6'b000011, 6'b000010};
        foreach (ops[i]) if (ops[i] == op) return 1;
        return 0;
    endfunction

    function automatic logic [7:0] ref_alu(input int a, input int b, input logic [5:0] op);
        int sa, q, p, r;
        sa = (a >= 128) ? a - 256 : a;
        r  = 0;
        case (op)
            6'b100000: r = (a + b) % 256;
            6'b100010: r = (a - b + 256) % 256;
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = 255 - (a | b);
            6'b000010: r = (b >= 8) ? 0 : a / (1 << b);
            6'b000011: begin
                if (b >= 8) r = (sa < 0) ? 255 : 0;
                else begin
                    p = 1 << b;
                    q = sa / p;
                    if (sa < 0 && q * p != sa) q = q - 1;
                    r = (q + 256) % 256;
                end
            end
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    task automatic load(input logic [7:0] v, input int gap);
        bus.i_data = v;
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        repeat (1 + gap) tick();
    endtask

    // Full A/B/op sequence with timing and result checks.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] op, input logic [1:0] hi, input int gap);
        logic [7:0] exp_r;
        int         sup;
        sup   = ref_supported(op);
        exp_r = sup ? ref_alu(int'(a), int'(b), op) : 8'h00;
        load(a, gap);
        load(b, gap);
        bus.i_data = {hi, op};
        bus.i_load = 1'b1;
        tick();
        check_val({tag, "_exec_state"}, 32'(bus.o_state), 32'd3);
        check_val({tag, "_exec_valid"}, 32'(bus.o_valid), 32'd0);
        bus.i_load = 1'b0;
        tick();
        check_val({tag, "_valid"},  32'(bus.o_valid),  32'd1);
        check_val({tag, "_state"},  32'(bus.o_state),  32'd4);
        check_val({tag, "_result"}, 32'(bus.o_result), 32'(exp_r));
        check_val({tag, "_error"},  32'(bus.o_error),  32'(sup == 0));
    endtask

    initial begin
        logic [5:0] op_tab [8];
        logic [5:0] op;
        logic [7:0] a, b;

        op_tab = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
        n_vec = 0;
        n_err = 0;

        // Reset with load already high: release must not capture.
        rst_n       = 1'b0;
        bus.i_data  = 8'h55;
        bus.i_load  = 1'b1;
        bus.i_clear = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_val("rst_state",  32'(bus.o_state),  32'd0);
        check_val("rst_valid",  32'(bus.o_valid),  32'd0);
        check_val("rst_result", 32'(bus.o_result), 32'd0);
        check_val("rst_error",  32'(bus.o_error),  32'd0);
        bus.i_load = 1'b0;
        tick();

        do_op("add_basic", 8'h05, 8'h03, OP_ADD, 2'b00, 0);
        do_op("add_wrap",  8'h7F, 8'h01, OP_ADD, 2'b00, 0);
        check_val("add_wrap_abs", 32'(bus.o_result), 32'h80);
        do_op("sra_neg",   8'h80, 8'h02, OP_SRA, 2'b00, 1);
        check_val("sra_neg_abs", 32'(bus.o_result), 32'hE0);
        do_op("srl_neg",   8'h80, 8'h02, OP_SRL, 2'b00, 0);
        check_val("srl_neg_abs", 32'(bus.o_result), 32'h20);
        do_op("sra_big",   8'h90, 8'h09, OP_SRA, 2'b00, 0);
        do_op("srl_big",   8'hFF, 8'h08, OP_SRL, 2'b00, 0);

        // Unsupported opcode, then next load edge drops valid/error.
        do_op("bad_op", 8'h12, 8'h34, 6'b111111, 2'b11, 0);
        load(8'h11, 0);
        check_val("bad_next_valid", 32'(bus.o_valid), 32'd0);
        check_val("bad_next_error", 32'(bus.o_error), 32'd0);
        check_val("bad_next_state", 32'(bus.o_state), 32'd1);
        load(8'h22, 0);
        load(8'h00, 0);
        tick();

        // Clear together with the opcode load edge wins.
        do_op("pre_clr", 8'h40, 8'h01, OP_OR, 2'b00, 0);
        load(8'h09, 0);
        load(8'h04, 0);
        bus.i_data  = {2'b00, OP_ADD};
        bus.i_load  = 1'b1;
        bus.i_clear = 1'b1;
        tick();
        check_val("clr_state",  32'(bus.o_state),  32'd0);
        check_val("clr_valid",  32'(bus.o_valid),  32'd0);
        check_val("clr_result", 32'(bus.o_result), 32'd0);
        bus.i_clear = 1'b0;
        bus.i_load  = 1'b0;
        tick();

        // Async reset pulse while waiting for the opcode.
        do_op("pre_rst", 8'h0F, 8'hF0, OP_XOR, 2'b00, 0);
        load(8'h01, 0);
        load(8'h02, 0);
        check_val("pre_rst_state", 32'(bus.o_state), 32'd2);
        rst_n = 1'b0;
        #2;
        check_val("arst_state",  32'(bus.o_state),  32'd0);
        check_val("arst_valid",  32'(bus.o_valid),  32'd0);
        check_val("arst_result", 32'(bus.o_result), 32'd0);
        check_val("arst_error",  32'(bus.o_error),  32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Held-high load captures A once only.
        bus.i_data = 8'h0A;
        bus.i_load = 1'b1;
        repeat (20) tick();
        check_val("hold_state", 32'(bus.o_state), 32'd1);
        bus.i_load = 1'b0;
        tick();
        load(8'h06, 0);
        check_val("hold_b_state", 32'(bus.o_state), 32'd2);
        // Load stays high through EXEC: no new edge, DONE still reached.
        bus.i_data = {2'b00, OP_SUB};
        bus.i_load = 1'b1;
        tick();
        check_val("exec_hold_state", 32'(bus.o_state), 32'd3);
        tick();
        check_val("exec_hold_done",   32'(bus.o_state),  32'd4);
        check_val("exec_hold_result", 32'(bus.o_result), 32'h04);
        check_val("exec_hold_valid",  32'(bus.o_valid),  32'd1);
        tick();
        check_val("done_hold_state", 32'(bus.o_state), 32'd4);
        bus.i_load = 1'b0;
        tick();

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
            else                           b = 8'($urandom_range(0, 10));
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else                           op = op_tab[$urandom_range(0, 7)];
            do_op($sformatf("rnd%0d", i), a, b, op, 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
